imsic_msi_sender: RTL and testbench

- MSI transmit side of the IMSIC delivery link.
- Accepts bus-side writes to a hart's interrupt-file seteipnum page and decodes each into {hart, file, setipnum}.
- Buffers writes in a small FIFO and replays them, one at a time, as msi_info plus an msi_info_vld pulse. The timing is chosen so a per-hart CSR-gate receiver can 2-flop-sync the valid and capture msi_info on its falling edge.

---
 rtl/imsic_pkg.sv | 59 +++++
 rtl/imsic_msi_fifo.sv | 56 +++++
 rtl/imsic_msi_sender.sv | 137 +++++++++++++
 tb/tb_imsic_msi_sender.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imsic_pkg.sv
// Shared IMSIC definitions: seteipnum page offsets, MSI_INFO field layout and
// the valid hold/gap timing that sender and CSR-gate receiver must agree on.
package imsic_pkg;

    localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
    localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_GAP
    } msi_state_e;

    // Receiver needs 2 sync flops + eid_vld_dly stages + 1 edge-detect stage.
    function automatic int hold_cycles(input int eid_vld_dly);
        return eid_vld_dly + 3;
    endfunction

    function automatic int gap_cycles(input int eid_vld_dly);
        return eid_vld_dly + 4;
    endfunction

    function automatic logic [31:0] bswap32(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    function automatic logic [31:0] field_mask(input int w);
        return (32'd1 << w) - 32'd1;
    endfunction

    // MSI_INFO = {hart, file, id}, hart in the MSBs.
    function automatic logic [31:0] msi_pack(input logic [31:0] hart,
                                             input logic [31:0] file,
                                             input logic [31:0] id,
                                             input int          file_w,
                                             input int          src_w);
        return (hart << (file_w + src_w))
             | ((file & field_mask(file_w)) << src_w)
             | (id & field_mask(src_w));
    endfunction

    function automatic logic [31:0] msi_hart(input logic [31:0] info,
                                             input int          file_w,
                                             input int          src_w);
        return info >> (file_w + src_w);
    endfunction

    function automatic logic [31:0] msi_file(input logic [31:0] info,
                                             input int          file_w,
                                             input int          src_w);
        return (info >> src_w) & field_mask(file_w);
    endfunction

    function automatic logic [31:0] msi_id(input logic [31:0] info,
                                           input int          src_w);
        return info & field_mask(src_w);
    endfunction

endpackage

// File: rtl/imsic_msi_fifo.sv
// Synchronous FIFO buffering decoded MSI requests between bus and replay FSM.
// Read data is the current head (show-ahead); pointers wrap modulo DEPTH.
module imsic_msi_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values of the others, matching real hardware.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; occupancy is tracked
    // by the pointers/count, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/imsic_msi_sender.sv
// IMSIC MSI transmit side: decodes seteipnum writes, buffers them and replays
// each as a held msi_info_vld level followed by a quiet gap.
module imsic_msi_sender
    import imsic_pkg::*;
#(
    parameter int NR_INTP_FILES  = 7,
    parameter int NR_HARTS       = 4,
    parameter int NR_HARTS_WIDTH = 2,
    parameter int NR_SRC         = 32,
    parameter int EID_VLD_DLY    = 0,
    parameter int FIFO_DEPTH     = 4,
    localparam int NR_SRC_WIDTH    = $clog2(NR_SRC),
    localparam int INTP_FILE_WIDTH = $clog2(NR_INTP_FILES),
    localparam int MSI_INFO_WIDTH  = NR_HARTS_WIDTH + INTP_FILE_WIDTH + NR_SRC_WIDTH,
    localparam int ADDR_WIDTH      = NR_HARTS_WIDTH + INTP_FILE_WIDTH + 12
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req_vld,
    output logic                      o_req_rdy,
    input  logic [ADDR_WIDTH-1:0]     i_req_addr,
    input  logic [31:0]               i_req_data,
    output logic [MSI_INFO_WIDTH-1:0] o_msi_info,
    output logic                      o_msi_info_vld,
    output logic                      o_drop,
    output logic                      o_busy
);

    localparam int HOLD_CYC = hold_cycles(EID_VLD_DLY);
    localparam int GAP_CYC  = gap_cycles(EID_VLD_DLY);
    localparam int TMR_W    = $clog2(GAP_CYC + 1);
    localparam int CNT_W    = $clog2(FIFO_DEPTH) + 1;

    logic [NR_HARTS_WIDTH-1:0]  req_hart;
    logic [INTP_FILE_WIDTH-1:0] req_file;
    logic [11:0]                req_off;
    logic [31:0]                req_id;
    logic                       off_ok;
    logic                       req_legal;
    logic                       hs;

    logic                       fifo_push;
    logic [MSI_INFO_WIDTH-1:0]  fifo_wdata;
    logic                       fifo_pop;
    logic [MSI_INFO_WIDTH-1:0]  fifo_rdata;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CNT_W-1:0]           fifo_count;

    msi_state_e                 state;
    logic [TMR_W-1:0]           tmr;

    assign hs       = i_req_vld && o_req_rdy;
    assign req_hart = i_req_addr[ADDR_WIDTH-1 -: NR_HARTS_WIDTH];
    assign req_file = i_req_addr[12 +: INTP_FILE_WIDTH];
    assign req_off  = i_req_addr[11:0];

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        req_id = i_req_data;
        off_ok = 1'b1;
        case (req_off)
            SETEIPNUM_LE_OFF: req_id = i_req_data;
            SETEIPNUM_BE_OFF: req_id = bswap32(i_req_data);
            default:          off_ok = 1'b0;
        endcase
    end

    // The id range check uses the full 32-bit value so 0x1_0005 cannot alias to 5.
    assign req_legal = off_ok
                    && (32'(req_file) < 32'(NR_INTP_FILES))
                    && (32'(req_hart) < 32'(NR_HARTS))
                    && (req_id != 32'd0)
                    && (req_id < 32'(NR_SRC));

    assign fifo_push  = hs && req_legal;
    assign fifo_wdata = MSI_INFO_WIDTH'(msi_pack(32'(req_hart), 32'(req_file), req_id,
                                                 INTP_FILE_WIDTH, NR_SRC_WIDTH));
    assign fifo_pop   = (state == ST_IDLE) && !fifo_empty;

    assign o_req_rdy = !fifo_full;
    assign o_busy    = (fifo_count != '0) || (state != ST_IDLE);

    imsic_msi_fifo #(
        .WIDTH (MSI_INFO_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // msi_info only changes on a pop, so it is stable through ASSERT and GAP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            tmr            <= '0;
            o_msi_info     <= '0;
            o_msi_info_vld <= 1'b0;
            o_drop         <= 1'b0;
        end else begin
            o_drop <= hs && !req_legal;
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        o_msi_info     <= fifo_rdata;
                        o_msi_info_vld <= 1'b1;
                        tmr            <= TMR_W'(HOLD_CYC - 1);
                        state          <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (tmr == '0) begin
                        o_msi_info_vld <= 1'b0;
                        tmr            <= TMR_W'(GAP_CYC - 1);
                        state          <= ST_GAP;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                ST_GAP: begin
                    if (tmr == '0) state <= ST_IDLE;
                    else           tmr   <= tmr - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imsic_msi_sender.sv
// Directed bench for imsic_msi_sender: timing, decode, drops, back-pressure,
// reset during transfer, and loop-back into a CSR-gate receiver model.
module tb_imsic_msi_sender;
    import imsic_pkg::*;

    localparam int AW = 17;
    localparam int IW = 10;
    localparam int RX_STAGES = 2 + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          req_vld = 1'b0;
    logic          req_rdy;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_data = '0;
    logic [IW-1:0] msi_info;
    logic          msi_vld;
    logic          drop;
    logic          busy;

    logic          req_vld1 = 1'b0;
    logic          req_rdy1;
    logic [AW-1:0] req_addr1 = '0;
    logic [31:0]   req_data1 = '0;
    logic [IW-1:0] msi_info1;
    logic          msi_vld1;
    logic          drop1;
    logic          busy1;

    imsic_msi_sender dut (
        .clk(clk), .rst(rst),
        .i_req_vld(req_vld), .o_req_rdy(req_rdy),
        .i_req_addr(req_addr), .i_req_data(req_data),
        .o_msi_info(msi_info), .o_msi_info_vld(msi_vld),
        .o_drop(drop), .o_busy(busy)
    );

    imsic_msi_sender #(.EID_VLD_DLY(1)) dut1 (
        .clk(clk), .rst(rst),
        .i_req_vld(req_vld1), .o_req_rdy(req_rdy1),
        .i_req_addr(req_addr1), .i_req_data(req_data1),
        .o_msi_info(msi_info1), .o_msi_info_vld(msi_vld1),
        .o_drop(drop1), .o_busy(busy1)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Edge monitor for dut, sampled on the falling clock edge.
    logic          vld_prev = 1'b0;
    int            rise_cnt = 0;
    int            drop_cnt = 0;
    int            rise_cyc[$];
    logic [IW-1:0] rise_info[$];
    always @(negedge clk) begin
        if (msi_vld && !vld_prev) begin
            rise_cnt <= rise_cnt + 1;
            rise_cyc.push_back(cyc);
            rise_info.push_back(msi_info);
        end
        if (drop) drop_cnt <= drop_cnt + 1;
        vld_prev <= msi_vld;
    end

    // CSR-gate receiver model for dut1: sync chain, capture on falling edge.
    logic [RX_STAGES:0] rx_sync = '0;
    logic [IW-1:0]      rx_q[$];
    int                 drop1_cnt = 0;
    always @(negedge clk) begin
        rx_sync <= {rx_sync[RX_STAGES-1:0], msi_vld1};
        if (rx_sync[RX_STAGES] && !rx_sync[RX_STAGES-1]) rx_q.push_back(msi_info1);
        if (drop1) drop1_cnt <= drop1_cnt + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Drive one write to dut; returns the handshake cycle.
    task automatic send0(input logic [AW-1:0] addr, input logic [31:0] data, output int t);
        int n = 0;
        req_addr = addr;
        req_data = data;
        req_vld  = 1'b1;
        while (!req_rdy && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!req_rdy) begin
            errors++;
            $display("FAIL send0_rdy_timeout: got rdy=%b expected 1 within 64 cycles", req_rdy);
        end
        t = cyc;
        @(posedge clk); #1;
        req_vld = 1'b0;
    endtask

    task automatic send1(input logic [AW-1:0] addr, input logic [31:0] data);
        int n = 0;
        req_addr1 = addr;
        req_data1 = data;
        req_vld1  = 1'b1;
        while (!req_rdy1 && n < 64) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (!req_rdy1) begin
            errors++;
            $display("FAIL send1_rdy_timeout: got rdy=%b expected 1 within 64 cycles", req_rdy1);
        end
        @(posedge clk); #1;
        req_vld1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (msi_info !== '0) begin errors++; $display("FAIL reset_info: got %h expected 000", msi_info); end
        checks++; if (msi_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", msi_vld); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (req_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy: got %b expected 1", req_rdy); end
        checks++; if (req_rdy1 !== 1'b1) begin errors++; $display("FAIL reset_rdy1: got %b expected 1", req_rdy1); end
        checks++; if (msi_vld1 !== 1'b0) begin errors++; $display("FAIL reset_vld1: got %b expected 0", msi_vld1); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy1: got %b expected 0", busy1); end
    endtask

    task automatic test_le_write();
        int t0;
        int d0 = drop_cnt;
        send0({2'd2, 3'd1, 12'h000}, 32'd5, t0);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if (msi_vld !== ((k >= 2) && (k <= 4))) begin
                errors++; $display("FAIL le_vld_c%0d: got %b expected %b", k, msi_vld, (k >= 2) && (k <= 4));
            end
            if (k >= 2 && k <= 8) begin
                checks++;
                if (msi_info !== {2'd2, 3'd1, 5'd5}) begin
                    errors++; $display("FAIL le_info_c%0d: got %h expected %h", k, msi_info, {2'd2, 3'd1, 5'd5});
                end
            end
            if (k == 1 || k == 9) begin
                checks++;
                if (busy !== (k == 1)) begin
                    errors++; $display("FAIL le_busy_c%0d: got %b expected %b", k, busy, k == 1);
                end
            end
        end
        checks++;
        if (drop_cnt != d0) begin errors++; $display("FAIL le_drop: got %0d pulses expected 0", drop_cnt - d0); end
    endtask

    task automatic test_be_write();
        int t0;
        int r0 = rise_cnt;
        int d0 = drop_cnt;
        send0({2'd1, 3'd3, 12'h004}, 32'h0700_0000, t0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (msi_vld !== 1'b1 || msi_info !== {2'd1, 3'd3, 5'd7}) begin
            errors++; $display("FAIL be_info: got vld=%b info=%h expected vld=1 info=%h", msi_vld, msi_info, {2'd1, 3'd3, 5'd7});
        end
        repeat (8) @(negedge clk);
        checks++;
        if (rise_cnt - r0 != 1 || drop_cnt != d0) begin
            errors++; $display("FAIL be_counts: got rises=%0d drops=%0d expected 1 and 0", rise_cnt - r0, drop_cnt - d0);
        end
        @(posedge clk); #1;
        r0 = rise_cnt;
        d0 = drop_cnt;
        send0({2'd1, 3'd3, 12'h004}, 32'h0000_0000, t0);
        @(negedge clk);
        checks++; if (drop !== 1'b1) begin errors++; $display("FAIL be_zero_drop_c1: got %b expected 1", drop); end
        @(negedge clk);
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL be_zero_drop_c2: got %b expected 0", drop); end
        repeat (8) @(negedge clk);
        checks++;
        if (rise_cnt != r0 || drop_cnt - d0 != 1) begin
            errors++; $display("FAIL be_zero_counts: got rises=%0d drops=%0d expected 0 and 1", rise_cnt - r0, drop_cnt - d0);
        end
    endtask

    task automatic test_out_of_range();
        logic [AW-1:0] addrs [4] = '{{2'd0, 3'd0, 12'h000}, {2'd1, 3'd7, 12'h000},
                                     {2'd3, 3'd2, 12'h000}, {2'd0, 3'd1, 12'h008}};
        logic [31:0]   datas [4] = '{32'd32, 32'd5, 32'h0001_0005, 32'd5};
        int t0;
        int r0;
        int d0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            r0 = rise_cnt;
            d0 = drop_cnt;
            send0(addrs[i], datas[i], t0);
            @(negedge clk);
            checks++;
            if (drop !== 1'b1 || busy !== 1'b0) begin
                errors++; $display("FAIL oor%0d_c1: got drop=%b busy=%b expected drop=1 busy=0", i, drop, busy);
            end
            @(negedge clk);
            checks++; if (drop !== 1'b0) begin errors++; $display("FAIL oor%0d_c2: got drop=%b expected 0", i, drop); end
            repeat (8) @(negedge clk);
            checks++;
            if (rise_cnt != r0 || drop_cnt - d0 != 1) begin
                errors++; $display("FAIL oor%0d_counts: got rises=%0d drops=%0d expected 0 and 1", i, rise_cnt - r0, drop_cnt - d0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] addrs [6] = '{{2'd0, 3'd0, 12'h000}, {2'd1, 3'd1, 12'h000}, {2'd2, 3'd2, 12'h000},
                                     {2'd3, 3'd3, 12'h000}, {2'd0, 3'd4, 12'h000}, {2'd1, 3'd5, 12'h000}};
        logic [IW-1:0] exp_info [6] = '{{2'd0, 3'd0, 5'd1}, {2'd1, 3'd1, 5'd2}, {2'd2, 3'd2, 5'd3},
                                        {2'd3, 3'd3, 5'd4}, {2'd0, 3'd4, 5'd5}, {2'd1, 3'd5, 5'd6}};
        int hs_cyc [6];
        int i = 0;
        int guard = 0;
        int first_stall = -1;
        int t0;
        int r0 = rise_cnt;
        int base = rise_cyc.size();
        @(posedge clk); #1;
        t0 = cyc;
        while (i < 6 && guard < 100) begin
            req_addr = addrs[i];
            req_data = 32'(i + 1);
            req_vld  = 1'b1;
            if (req_rdy) begin
                hs_cyc[i] = cyc;
                i++;
            end else if (first_stall < 0) begin
                first_stall = cyc;
            end
            @(posedge clk); #1;
            guard++;
        end
        req_vld = 1'b0;
        checks++; if (i != 6) begin errors++; $display("FAIL b2b_accept: got %0d accepted expected 6", i); end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (hs_cyc[k] != t0 + k) begin
                errors++; $display("FAIL b2b_hs%0d: got cycle +%0d expected +%0d", k, hs_cyc[k] - t0, k);
            end
        end
        checks++; if (first_stall != t0 + 5) begin errors++; $display("FAIL b2b_rdy_low: got cycle +%0d expected +5", first_stall - t0); end
        checks++; if (hs_cyc[5] != t0 + 10) begin errors++; $display("FAIL b2b_hs5: got cycle +%0d expected +10", hs_cyc[5] - t0); end
        repeat (42) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end: got %b expected 0", busy); end
        checks++; if (rise_cnt - r0 != 6) begin errors++; $display("FAIL b2b_rises: got %0d expected 6", rise_cnt - r0); end
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (rise_cyc.size() <= base + k) begin
                errors++; $display("FAIL b2b_rise%0d: got no rise expected one at +%0d", k, 2 + 8 * k);
            end else if (rise_cyc[base + k] != t0 + 2 + 8 * k || rise_info[base + k] !== exp_info[k]) begin
                errors++; $display("FAIL b2b_rise%0d: got cycle +%0d info %h expected +%0d info %h",
                                   k, rise_cyc[base + k] - t0, rise_info[base + k], 2 + 8 * k, exp_info[k]);
            end
        end
    endtask

    task automatic test_reset_mid_transfer();
        int t0;
        int r0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            req_addr = {2'd0, 3'd0, 12'h000};
            req_data = 32'(i + 1);
            req_vld  = 1'b1;
            @(posedge clk); #1;
        end
        req_vld = 1'b0;
        checks++;
        if (msi_vld !== 1'b1 || busy !== 1'b1) begin
            errors++; $display("FAIL rstmid_pre: got vld=%b busy=%b expected 1 1", msi_vld, busy);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (msi_vld !== 1'b0 || busy !== 1'b0 || req_rdy !== 1'b1 || msi_info !== '0) begin
            errors++; $display("FAIL rstmid_post: got vld=%b busy=%b rdy=%b info=%h expected 0 0 1 000",
                               msi_vld, busy, req_rdy, msi_info);
        end
        r0 = rise_cnt;
        repeat (20) @(negedge clk);
        checks++; if (rise_cnt != r0) begin errors++; $display("FAIL rstmid_quiet: got %0d rises expected 0", rise_cnt - r0); end
        @(posedge clk); #1;
        send0({2'd3, 3'd6, 12'h000}, 32'd31, t0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (msi_vld !== 1'b1 || msi_info !== {2'd3, 3'd6, 5'd31}) begin
            errors++; $display("FAIL rstmid_fresh: got vld=%b info=%h expected vld=1 info=%h", msi_vld, msi_info, {2'd3, 3'd6, 5'd31});
        end
        repeat (8) @(negedge clk);
        checks++; if (rise_cnt - r0 != 1) begin errors++; $display("FAIL rstmid_fresh_rises: got %0d expected 1", rise_cnt - r0); end
    endtask

    task automatic test_loopback();
        logic [IW-1:0] exp_q[$];
        logic [31:0]   h;
        logic [31:0]   f;
        logic [31:0]   id;
        logic          be;
        int            rx0 = rx_q.size();
        int            n = 0;
        @(posedge clk); #1;
        for (int i = 0; i < 100; i++) begin
            h  = $urandom_range(0, 3);
            f  = $urandom_range(0, 6);
            id = $urandom_range(1, 31);
            be = 1'($urandom_range(0, 1));
            exp_q.push_back({h[1:0], f[2:0], id[4:0]});
            send1({h[1:0], f[2:0], be ? 12'h004 : 12'h000},
                  be ? {id[7:0], id[15:8], id[23:16], id[31:24]} : id);
        end
        while (rx_q.size() < rx0 + 100 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (12) @(negedge clk);
        checks++;
        if (rx_q.size() != rx0 + 100) begin
            errors++; $display("FAIL loop_count: got %0d captures expected 100", rx_q.size() - rx0);
        end
        checks++; if (drop1_cnt != 0) begin errors++; $display("FAIL loop_drops: got %0d expected 0", drop1_cnt); end
        checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL loop_busy_end: got %b expected 0", busy1); end
        for (int k = 0; k < 100 && rx0 + k < rx_q.size(); k++) begin
            checks++;
            if (rx_q[rx0 + k] !== exp_q[k]) begin
                errors++;
                $display("FAIL loop_item%0d: got hart=%0d file=%0d id=%0d expected hart=%0d file=%0d id=%0d", k,
                         msi_hart(32'(rx_q[rx0 + k]), 3, 5), msi_file(32'(rx_q[rx0 + k]), 3, 5), msi_id(32'(rx_q[rx0 + k]), 5),
                         msi_hart(32'(exp_q[k]), 3, 5), msi_file(32'(exp_q[k]), 3, 5), msi_id(32'(exp_q[k]), 5));
            end
        end
    endtask

    initial begin
        test_reset();
        test_le_write();
        @(posedge clk); #1;
        test_be_write();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_transfer();
        test_loopback();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
